// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply result path.
// Holds widths, the sender state type and the C-tile packing helper.
package mm_pkg;

  localparam int MM_DATA_W = 1024;
  localparam int MM_FLAG_W = 32;
  localparam int MM_CF_W   = MM_DATA_W + MM_FLAG_W;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_RUN,
    SND_DRAIN,
    SND_DONE
  } mm_snd_state_t;

  // Flags sit above the payload so the write controller can split on bit 1024.
  function automatic logic [MM_CF_W-1:0] mm_pack_cf(
    input logic [MM_FLAG_W-1:0] flags,
    input logic [MM_DATA_W-1:0] data
  );
    return {flags, data};
  endfunction

endpackage

// File: rtl/mm_result_fifo.sv
// Small result FIFO with a registered head word.
// The head register is refreshed from memory or the incoming word on pop/push.
module mm_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  head_q;
  logic [W-1:0]  head_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign rd_nxt  = rd_q + PW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - CW'(1);
  end

  // With one entry left, a same-cycle push becomes the new head directly.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (cnt_q > CW'(1))
        head_d = mem_q[rd_nxt];
      else if (do_push)
        head_d = data_i;
    end else if (do_push && cnt_q == '0) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + PW'(1);
      if (do_pop)
        rd_q <= rd_nxt;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/mm_store_sender.sv
// Accelerator-side store transmitter: buffers finished C tiles and
// hands them to the RAM write controller, pulsing finish per job.
import mm_pkg::*;

module mm_store_sender #(
  parameter int DATA_W    = MM_DATA_W,
  parameter int FLAG_W    = MM_FLAG_W,
  parameter int DEPTH     = 2,
  parameter int NUM_TILES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     res_valid,
  input  logic [DATA_W-1:0]        res_data,
  input  logic [FLAG_W-1:0]        res_flags,
  output logic                     res_ready,
  output logic                     store_C,
  output logic [DATA_W+FLAG_W-1:0] dataCf_out,
  input  logic                     store_C_ready,
  output logic                     finish,
  output logic                     busy
);

  localparam int CNT_W = $clog2(NUM_TILES+1);
  localparam int FCW   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_TILES-1);
  localparam logic [CNT_W-1:0] TILES = CNT_W'(NUM_TILES);
  localparam logic [FCW-1:0]   FULL  = FCW'(DEPTH);

  mm_snd_state_t    state_q;
  mm_snd_state_t    state_d;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] acc_cnt_d;
  logic [CNT_W-1:0] sent_cnt_q;
  logic [CNT_W-1:0] sent_cnt_d;
  logic [FCW-1:0]   fifo_cnt;
  logic             push;
  logic             pop;

  assign push = res_valid && res_ready;
  assign pop  = store_C && store_C_ready;

  mm_result_fifo #(
    .W     (DATA_W+FLAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (mm_pack_cf(res_flags, res_data)),
    .pop_i   (pop),
    .head_o  (dataCf_out),
    .count_o (fifo_cnt)
  );

  assign store_C = (fifo_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= SND_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SND_IDLE:  if (start) state_d = SND_RUN;
      SND_RUN:   if (push && acc_cnt_q == LAST) state_d = SND_DRAIN;
      SND_DRAIN: if (pop && sent_cnt_q == LAST) state_d = SND_DONE;
      SND_DONE:  state_d = SND_IDLE;
      default:   state_d = SND_IDLE;
    endcase
  end

  // Ready looks only at registered occupancy, never at this cycle's pop.
  always_comb begin
    res_ready = (state_q == SND_RUN) &&
                (fifo_cnt < FULL) &&
                (acc_cnt_q < TILES);
    finish    = (state_q == SND_DONE);
    busy      = (state_q != SND_IDLE);
  end

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    sent_cnt_d = sent_cnt_q;
    if (state_q == SND_IDLE && start) begin
      acc_cnt_d  = '0;
      sent_cnt_d = '0;
    end else begin
      if (push)
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      if (pop && sent_cnt_q < TILES)
        sent_cnt_d = sent_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

endmodule

// File: tb/tb_mm_store_sender.sv
// Scoreboard bench for mm_store_sender: driver queues expected tiles,
// a negedge monitor checks every store, finish pulse and occupancy.
module tb_mm_store_sender;

  localparam int DW = 1024;
  localparam int FW = 32;
  localparam int CW = DW + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic [FW-1:0] res_flags = '0;
  logic          res_ready;
  logic          store_C;
  logic [CW-1:0] dataCf_out;
  logic          store_C_ready = 1'b0;
  logic          finish;
  logic          busy;

  always #5 clk = ~clk;

  mm_store_sender dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_flags     (res_flags),
    .res_ready     (res_ready),
    .store_C       (store_C),
    .dataCf_out    (dataCf_out),
    .store_C_ready (store_C_ready),
    .finish        (finish),
    .busy          (busy)
  );

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] sb[$];
  int scyc[$];
  int cyc = 0;
  int n_store = 0;
  int n_finish = 0;
  int last_store_cyc = -10;
  int occ = 0;
  bit prev_fin = 1'b0;
  bit rdy_rand = 1'b0;
  bit rdy_fix = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cf(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%h hi=%h lo=%h expected flags=%h hi=%h lo=%h",
               nm, act[CW-1:DW], act[DW-1:DW-32], act[31:0],
               exp[CW-1:DW], exp[DW-1:DW-32], exp[31:0]);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #2;
    store_C_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      prev_fin = 1'b0;
    end else begin
      if (prev_fin)
        chk("idle_after_finish", {62'd0, busy, finish}, 64'd0);
      if (res_valid && res_ready)
        occ++;
      if (store_C && store_C_ready) begin
        n_store++;
        scyc.push_back(cyc);
        last_store_cyc = cyc;
        occ--;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL store_unexpected: got flags=%h with no tile pending",
                   dataCf_out[CW-1:DW]);
        end else begin
          chk_cf("store_data", dataCf_out, sb.pop_front());
        end
      end
      if ((res_valid && res_ready) || (store_C && store_C_ready)) begin
        checks++;
        if (occ > 2 || occ < 0) begin
          errors++;
          $display("FAIL fifo_occ: got %0d required 0..2", occ);
        end
      end
      if (finish) begin
        n_finish++;
        chk("finish_latency", 64'(cyc - last_store_cyc), 64'd1);
      end
      prev_fin = finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_tile(input logic [FW-1:0] f, input logic [DW-1:0] d);
    bit done = 1'b0;
    res_valid = 1'b1;
    res_flags = f;
    res_data  = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (res_ready) begin
        sb.push_back({f, d});
        done = 1'b1;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tile flags=%h never accepted", f);
    end
  endtask

  task automatic wait_finish(input int target);
    int k = 0;
    while (n_finish < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("job_finish", 64'(n_finish), 64'(target));
    step();
  endtask

  initial begin
    int base;
    int fb;
    logic [31:0] w;
    logic [CW-1:0] t1;

    #12;
    chk("rst_res_ready", {63'd0, res_ready}, 64'd0);
    chk("rst_store_C", {63'd0, store_C}, 64'd0);
    chk("rst_finish", {63'd0, finish}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk_cf("rst_dataCf", dataCf_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic job, ready held high
    rdy_fix = 1'b1;
    pulse_start();
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_ready", {63'd0, res_ready}, 64'd1);
    base = n_store;
    for (int i = 1; i <= 4; i++)
      send_tile(32'(i), DW'(i));
    res_valid = 1'b0;
    wait_finish(1);
    chk("basic_stores", 64'(n_store - base), 64'd4);
    chk("basic_b2b", 64'(scyc[base+3] - scyc[base]), 64'd3);

    // backpressure
    rdy_fix = 1'b0;
    pulse_start();
    t1 = {32'hB0B0_0001, {32{32'h1111_0001}}};
    send_tile(32'hB0B0_0001, {32{32'h1111_0001}});
    send_tile(32'hB0B0_0002, {32{32'h2222_0002}});
    res_valid = 1'b1;
    res_flags = 32'hB0B0_0003;
    res_data  = {32{32'h3333_0003}};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_ready_low", {63'd0, res_ready}, 64'd0);
      chk("bp_store_C", {63'd0, store_C}, 64'd1);
      chk_cf("bp_stable", dataCf_out, t1);
      step();
    end
    rdy_fix = 1'b1;
    send_tile(32'hB0B0_0003, {32{32'h3333_0003}});
    send_tile(32'hB0B0_0004, {32{32'h4444_0004}});
    res_valid = 1'b0;
    wait_finish(2);

    // res_valid in IDLE is ignored
    res_valid = 1'b1;
    res_flags = 32'hDEAD_0000;
    res_data  = {32{32'hDEAD_BEEF}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ready_low", {63'd0, res_ready}, 64'd0);
      chk("idle_store_C", {63'd0, store_C}, 64'd0);
      step();
    end
    res_valid = 1'b0;

    // wrap-around with random store_C_ready
    rdy_rand = 1'b1;
    fb = n_finish;
    for (int j = 0; j < 4; j++) begin
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        w = 32'hC0DE_0000 | 32'(j * 16 + i);
        send_tile(32'h0000_0100 + 32'(j * 16 + i), {32{w}});
      end
      res_valid = 1'b0;
      wait_finish(fb + j + 1);
    end
    rdy_rand = 1'b0;

    // start during RUN ignored, extra tile in DRAIN refused
    rdy_fix = 1'b0;
    fb = n_finish;
    pulse_start();
    send_tile(32'h5EED_0001, {32{32'hAAAA_0001}});
    send_tile(32'h5EED_0002, {32{32'hAAAA_0002}});
    res_valid = 1'b0;
    pulse_start();
    chk("run_start_busy", {63'd0, busy}, 64'd1);
    rdy_fix = 1'b1;
    send_tile(32'h5EED_0003, {32{32'hAAAA_0003}});
    send_tile(32'h5EED_0004, {32{32'hAAAA_0004}});
    rdy_fix = 1'b0;
    res_flags = 32'h5EED_0005;
    res_data  = {32{32'hAAAA_0005}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("drain_ready_low", {63'd0, res_ready}, 64'd0);
      chk("drain_busy", {63'd0, busy}, 64'd1);
      step();
    end
    res_valid = 1'b0;
    rdy_fix = 1'b1;
    wait_finish(fb + 1);
    for (int k = 0; k < 4; k++) step();
    chk("no_restart_busy", {63'd0, busy}, 64'd0);
    chk("single_finish", 64'(n_finish), 64'(fb + 1));

    // reset mid-job
    rdy_fix = 1'b1;
    pulse_start();
    base = n_store;
    send_tile(32'hEE00_0001, {32{32'h7777_0001}});
    send_tile(32'hEE00_0002, {32{32'h7777_0002}});
    send_tile(32'hEE00_0003, {32{32'h7777_0003}});
    rdy_fix = 1'b0;
    res_valid = 1'b0;
    chk("rst_pre_stored", 64'(n_store - base), 64'd2);
    chk("rst_pre_store_C", {63'd0, store_C}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_store_C", {63'd0, store_C}, 64'd0);
    chk("rst_mid_finish", {63'd0, finish}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_ready", {63'd0, res_ready}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fb = n_finish;
    for (int k = 0; k < 3; k++) step();
    chk("rst_no_finish", 64'(n_finish), 64'(fb));
    rdy_fix = 1'b1;
    pulse_start();
    base = n_store;
    for (int i = 1; i <= 4; i++)
      send_tile(32'hF000_0000 | 32'(i), {32{32'h9999_0000 | 32'(i)}});
    res_valid = 1'b0;
    wait_finish(fb + 1);
    chk("rst_job_stores", 64'(n_store - base), 64'd4);

    for (int k = 0; k < 3; k++) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
